// File: rtl/btn_intr_ctrl.sv
// btn_intr_ctrl
//   Front-end for the OTTER interrupt push-button. The raw button goes through a
//   two-flop synchronizer and a four-state debounce FSM. Each accepted press raises
//   a level interrupt that stays high until the CPU acknowledges it. The block also
//   keeps a wrapping press counter and a sticky missed-press flag.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   btn_in       raw asynchronous button level
//   intr_en      interrupt enable (counting and debouncing continue when 0)
//   intr_ack     single-cycle acknowledge; clears intr and missed
//   intr         level interrupt request
//   btn_db       debounced button level
//   press_pulse  one-cycle pulse per accepted press
//   press_cnt    accepted-press count, wraps modulo 2^CNT_W
//   missed       sticky: a press was accepted while intr was already pending
module btn_intr_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             intr_en,
    input  logic             intr_ack,
    output logic             intr,
    output logic             btn_db,
    output logic             press_pulse,
    output logic [CNT_W-1:0] press_cnt,
    output logic             missed
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitHi,
        StPressed,
        StWaitLo
    } state_e;

    localparam logic [16:0] DebLen = 17'(DEBOUNCE_CYCLES);
    localparam bit          DebOne = (DEBOUNCE_CYCLES == 1);

    state_e             state_q, state_d;
    logic               s1_q, s2_q;
    logic [15:0]        cnt_q, cnt_d;
    logic               intr_q, intr_d;
    logic               missed_q, missed_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
    logic               press;
    logic               cnt_done;

    // Widened by one bit so that cnt_q = 16'hffff cannot wrap into a false match.
    assign cnt_done = (({1'b0, cnt_q} + 17'd1) == DebLen);

    // Debounce FSM; press marks an entry into StPressed from the low side only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s2_q) begin
                    if (DebOne) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        press   = 1'b1;
                    end else begin
                        state_d = StWaitHi;
                        cnt_d   = 16'd1;
                    end
                end
            end
            StWaitHi: begin
                if (!s2_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StPressed: begin
                if (!s2_q) begin
                    if (DebOne) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StWaitLo;
                        cnt_d   = 16'd1;
                    end
                end
            end
            StWaitLo: begin
                if (s2_q) begin
                    // Release bounce: back to stable high, not a new press.
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Interrupt bookkeeping. A press with intr_en wins over a simultaneous ack so
    // the new request is not lost; the ack still clears missed.
    always_comb begin
        pulse_d     = press;
        press_cnt_d = press_cnt_q;
        intr_d      = intr_q;
        missed_d    = missed_q;
        if (press) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
        if (intr_ack) begin
            intr_d   = 1'b0;
            missed_d = 1'b0;
        end else if (press && intr_en && intr_q) begin
            missed_d = 1'b1;
        end
        if (press && intr_en) begin
            intr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            intr_q      <= 1'b0;
            missed_q    <= 1'b0;
            pulse_q     <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            s1_q        <= btn_in;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            intr_q      <= intr_d;
            missed_q    <= missed_d;
            pulse_q     <= pulse_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // btn_db is a decode of the registered state, so it never follows an input
    // combinationally.
    assign btn_db      = (state_q == StPressed) || (state_q == StWaitLo);
    assign intr        = intr_q;
    assign missed      = missed_q;
    assign press_pulse = pulse_q;
    assign press_cnt   = press_cnt_q;

endmodule

// File: doc/btn_intr_ctrl.md
# btn_intr_ctrl

Front-end for a single OTTER push-button (the interrupt button, `buttons[4]` in the wrapper). It synchronizes the raw asynchronous button and debounces it with a 4-state FSM. Each accepted press becomes a level interrupt request to the MCU, held until the CPU acknowledges it. It also keeps a press counter and a sticky missed-press flag for the wrapper's I/O read port.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 2: consecutive sampled cycles a level must hold to be accepted. Legal range 1..65535.
- `CNT_W`, default 8: width of `press_cnt`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  raw asynchronous button level.
- `intr_en`  in  1  interrupt enable. When 0, presses are still counted and `btn_db` still tracks the button, but `intr` is not set.
- `intr_ack`  in  1  single-cycle acknowledge from the CPU; clears `intr` and `missed`.
- `intr`  out  1  level interrupt request to the MCU.
- `btn_db`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle pulse on each accepted press.
- `press_cnt`  out  `CNT_W`  accepted-press count; wraps modulo 2^`CNT_W`.
- `missed`  out  1  sticky flag: a press was accepted while `intr` was already pending.

## Operation
- Synchronizer: two flops, `s1` <= `btn_in`, then `s2` <= `s1`. Only `s2` feeds the FSM. Both flops reset to 0.
- Debounce counter `cnt`: 16 bits. It is loaded or cleared on every state transition as described below.
- FSM states:
  - IDLE (stable low, `btn_db`=0).
    - `s2`=1 and D=1: go to PRESSED.
    - `s2`=1 and D>1: go to WAIT_HI with `cnt`=1.
  - WAIT_HI.
    - `s2`=0: go to IDLE; `cnt` cleared.
    - `s2`=1 and `cnt`+1 == D: go to PRESSED.
    - Otherwise: `cnt`++.
  - PRESSED (stable high, `btn_db`=1).
    - `s2`=0 and D=1: go to IDLE.
    - `s2`=0 and D>1: go to WAIT_LO with `cnt`=1.
  - WAIT_LO (`btn_db` stays 1).
    - `s2`=1: go to PRESSED. This is a bounce; no new press.
    - `s2`=0 and `cnt`+1 == D: go to IDLE.
    - Otherwise: `cnt`++.
- Accepted press: any transition into PRESSED from IDLE or WAIT_HI. A return from WAIT_LO is not a press.
- On an accepted press, in the same edge:
  - `press_pulse`=1 for one cycle.
  - `press_cnt`++ (wraps).
  - If `intr_en`=1 and `intr`=1 and `intr_ack`=0: set `missed`.
  - If `intr_en`=1: set `intr`.
- `intr_ack`=1 clears `intr` and `missed` at the next edge, except:
  - If an accepted press with `intr_en`=1 occurs on the same edge, `intr` stays 1, `missed` is cleared, and the new press is not lost.
- `intr_ack` while `intr`=0: no effect.
- Deasserting `intr_en` does not clear a pending `intr`. Only `intr_ack` or `rst` clears it.
- Reset mid-operation:
  - FSM returns to IDLE; all outputs and `cnt` clear.
  - A button still held through reset release is seen as a new press D+2 cycles after `rst` falls.

## Timing
- Reset values: `intr`=0, `btn_db`=0, `press_pulse`=0, `press_cnt`=0, `missed`=0. FSM in IDLE, `s1`=`s2`=0.
- All outputs are registered; none is combinationally dependent on any input.
- Press latency: let E0 be the first edge that samples `btn_in`=1. If `btn_in` stays 1 through E0+D-1, then `btn_db`, `intr` and `press_pulse` go high after edge E0+D+1.
- Release latency: symmetric, `btn_db` falls after edge E0'+D+1, where E0' is the first edge sampling 0.
- Rejection: a high glitch sampled fewer than D times produces no output change.
- `intr` clears one edge after the edge that samples `intr_ack`=1.

## Test plan
- Reset and 30 ns press, D=2, 10 ns clock: hold `rst` 3 cycles, keep `btn_in`=0, then a 30 ns `btn_in` pulse with `intr_en`=1.
  - During reset: all outputs 0.
  - After the pulse: `btn_db`/`intr` rise at E0+3, `press_pulse` is high exactly 1 cycle, `press_cnt`=1.
- Glitch rejection, D=4: 20 ns pulse, then a 30 ns pulse. -> No `press_pulse`; `press_cnt` stays 0; FSM back in IDLE.
- Four presses spaced 430 ns, no ack (the 4×(30+400 ns) pattern).
  - `press_cnt`=4.
  - `intr` stays 1 throughout.
  - `missed` rises on the 2nd press and stays set.
  - Then pulse `intr_ack`: `intr`=0 and `missed`=0 one cycle later.
- Ack collision: assert `intr_ack` on the exact edge a new press is accepted, with `intr`=1. -> `intr` stays 1, `missed`=0, `press_cnt`++.
- Release bounce, D=3: after PRESSED, drive `btn_in` as 0 for 1 cycle, 1 for 1 cycle, then 0 steady.
  - `btn_db` stays 1 through the bounce, falls 5 cycles after the steady 0.
  - No extra `press_pulse`.
- Counter wrap, `intr_en`=0, `CNT_W`=8: 256 presses. -> `press_cnt` wraps 255→0; `intr` never asserts.
